// File: rtl/baccarat_pkg.sv
// Shared types and helpers for the baccarat round logic.
//   state_t      : round controller state encoding
//   card_value() : maps a raw card rank (0-15) to its baccarat point value
//   SCORE_W / CARD_W and default rule thresholds
package baccarat_pkg;

    localparam int SCORE_W = 4;
    localparam int CARD_W  = 4;

    localparam int NATURAL_MIN_DEF     = 8;
    localparam int PLAYER_DRAW_MAX_DEF = 5;
    localparam int BANKER_DRAW_MAX_DEF = 5;

    typedef enum logic [3:0] {
        W_P1, W_D1, W_P2, W_D2, W_P3, W_D3,
        L_P1, L_D1, L_P2, L_D2, L_P3, L_D3,
        CHK, CHK3, RES, DONE
    } state_t;

    // Tens and face cards (ranks 10-15) count as zero.
    function automatic logic [SCORE_W-1:0] card_value(input logic [CARD_W-1:0] rank);
        return (rank >= CARD_W'(10)) ? '0 : SCORE_W'(rank);
    endfunction

endpackage

// File: rtl/banker_draw_rule.sv
// Banker third-card decision once the player has drawn.
// Ports:
//   dscore : banker two-card score
//   pvalue : point value of the player's third card
//   draw   : 1 = banker takes a third card
module banker_draw_rule
    import baccarat_pkg::*;
(
    input  logic [SCORE_W-1:0] dscore,
    input  logic [SCORE_W-1:0] pvalue,
    output logic               draw
);

    always_comb begin
        draw = 1'b0;
        case (dscore)
            4'd0, 4'd1, 4'd2: draw = 1'b1;
            4'd3:             draw = (pvalue != 4'd8);
            4'd4:             draw = (pvalue >= 4'd2) && (pvalue <= 4'd7);
            4'd5:             draw = (pvalue >= 4'd4) && (pvalue <= 4'd7);
            4'd6:             draw = (pvalue >= 4'd6) && (pvalue <= 4'd7);
            default:          draw = 1'b0;
        endcase
    end

endmodule

// File: rtl/deal_sequencer.sv
// Baccarat round controller: steps the card-load strobes on deal requests,
// applies natural / third-card rules and drives the win lights.
// Ports:
//   slow_clock, resetb         : clock (rising edge), async active-low reset
//   deal_req                   : level-sampled deal-step request
//   pscore, dscore             : hand scores from the scorehand blocks
//   pcard3                     : raw rank of the player third card
//   load_pcard1..3/dcard1..3   : one-cycle card register load strobes
//   player_win_light/dealer_.. : result lights (both on a tie)
//   done                       : round complete, held until reset
//
// state | meaning
// W_xx  | waiting for deal_req to load card xx
// L_xx  | load strobe for card xx is high this cycle
// CHK   | two-card scores settled: natural / player draw / banker draw
// CHK3  | player third card loaded: banker rule on dscore and card value
// RES   | final scores settled: set lights
// DONE  | round over, hold lights, ignore deal_req
module deal_sequencer
    import baccarat_pkg::*;
#(
    parameter int NATURAL_MIN     = NATURAL_MIN_DEF,
    parameter int PLAYER_DRAW_MAX = PLAYER_DRAW_MAX_DEF,
    parameter int BANKER_DRAW_MAX = BANKER_DRAW_MAX_DEF
) (
    input  logic               slow_clock,
    input  logic               resetb,
    input  logic               deal_req,
    input  logic [SCORE_W-1:0] pscore,
    input  logic [SCORE_W-1:0] dscore,
    input  logic [CARD_W-1:0]  pcard3,
    output logic               load_pcard1,
    output logic               load_pcard2,
    output logic               load_pcard3,
    output logic               load_dcard1,
    output logic               load_dcard2,
    output logic               load_dcard3,
    output logic               player_win_light,
    output logic               dealer_win_light,
    output logic               done
);

    localparam logic [SCORE_W-1:0] NAT_MIN  = SCORE_W'(NATURAL_MIN);
    localparam logic [SCORE_W-1:0] P_MAX    = SCORE_W'(PLAYER_DRAW_MAX);
    localparam logic [SCORE_W-1:0] B_MAX    = SCORE_W'(BANKER_DRAW_MAX);

    state_t state;
    logic   banker_draw;

    banker_draw_rule u_banker_draw_rule (
        .dscore (dscore),
        .pvalue (card_value(pcard3)),
        .draw   (banker_draw)
    );

    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            state            <= W_P1;
            load_pcard1      <= 1'b0;
            load_pcard2      <= 1'b0;
            load_pcard3      <= 1'b0;
            load_dcard1      <= 1'b0;
            load_dcard2      <= 1'b0;
            load_dcard3      <= 1'b0;
            player_win_light <= 1'b0;
            dealer_win_light <= 1'b0;
            done             <= 1'b0;
        end else begin
            // Strobes last exactly one cycle; only the W->L transition raises one.
            load_pcard1 <= 1'b0;
            load_pcard2 <= 1'b0;
            load_pcard3 <= 1'b0;
            load_dcard1 <= 1'b0;
            load_dcard2 <= 1'b0;
            load_dcard3 <= 1'b0;
            case (state)
                W_P1: if (deal_req) begin state <= L_P1; load_pcard1 <= 1'b1; end
                W_D1: if (deal_req) begin state <= L_D1; load_dcard1 <= 1'b1; end
                W_P2: if (deal_req) begin state <= L_P2; load_pcard2 <= 1'b1; end
                W_D2: if (deal_req) begin state <= L_D2; load_dcard2 <= 1'b1; end
                W_P3: if (deal_req) begin state <= L_P3; load_pcard3 <= 1'b1; end
                W_D3: if (deal_req) begin state <= L_D3; load_dcard3 <= 1'b1; end
                L_P1: state <= W_D1;
                L_D1: state <= W_P2;
                L_P2: state <= W_D2;
                L_D2: state <= CHK;
                L_P3: state <= CHK3;
                L_D3: state <= RES;
                CHK: begin
                    if (pscore >= NAT_MIN || dscore >= NAT_MIN)
                        state <= RES;
                    else if (pscore <= P_MAX)
                        state <= W_P3;
                    else if (dscore <= B_MAX)
                        state <= W_D3;
                    else
                        state <= RES;
                end
                CHK3: state <= banker_draw ? W_D3 : RES;
                RES: begin
                    player_win_light <= (pscore >= dscore);
                    dealer_win_light <= (dscore >= pscore);
                    done             <= 1'b1;
                    state            <= DONE;
                end
                DONE:    state <= DONE;
                default: state <= W_P1;
            endcase
        end
    end

endmodule

// File: tb/tb_deal_sequencer.sv
module tb_deal_sequencer;

    logic       slow_clock = 1'b0;
    logic       resetb     = 1'b0;
    logic       deal_req   = 1'b0;
    logic [3:0] pscore     = '0;
    logic [3:0] dscore     = '0;
    logic [3:0] pcard3     = '0;
    logic load_pcard1, load_pcard2, load_pcard3;
    logic load_dcard1, load_dcard2, load_dcard3;
    logic player_win_light, dealer_win_light, done;

    deal_sequencer dut (
        .slow_clock       (slow_clock),
        .resetb           (resetb),
        .deal_req         (deal_req),
        .pscore           (pscore),
        .dscore           (dscore),
        .pcard3           (pcard3),
        .load_pcard1      (load_pcard1),
        .load_pcard2      (load_pcard2),
        .load_pcard3      (load_pcard3),
        .load_dcard1      (load_dcard1),
        .load_dcard2      (load_dcard2),
        .load_dcard3      (load_dcard3),
        .player_win_light (player_win_light),
        .dealer_win_light (dealer_win_light),
        .done             (done)
    );

    always #5 slow_clock = ~slow_clock;

    // Observed word: {done, player, dealer, ld3, ld2, ld1, lp3, lp2, lp1}
    localparam logic [5:0] LP1 = 6'b000001;
    localparam logic [5:0] LP2 = 6'b000010;
    localparam logic [5:0] LP3 = 6'b000100;
    localparam logic [5:0] LD1 = 6'b001000;
    localparam logic [5:0] LD2 = 6'b010000;
    localparam logic [5:0] LD3 = 6'b100000;

    logic [8:0] obs;
    assign obs = {done, player_win_light, dealer_win_light,
                  load_dcard3, load_dcard2, load_dcard1,
                  load_pcard3, load_pcard2, load_pcard1};

    int n_cmp = 0;
    int n_bad = 0;
    logic [8:0] sb[$];
    logic done_q = 1'b0;

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Monitor: pops an expected word whenever a strobe is seen or done rises.
    always @(negedge slow_clock) begin
        if (resetb && (obs[5:0] != 6'b0 || (done && !done_q))) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: got %b expected no event", obs);
            end else begin
                chk("scoreboard", obs, sb.pop_front());
            end
        end
        done_q = done;
    end

    task automatic rst_pulse();
        @(negedge slow_clock);
        #1 resetb = 1'b0;
        #1 chk("reset_zero", obs, 9'b0);
        @(negedge slow_clock);
        #1 resetb = 1'b1;
    endtask

    task automatic step(input logic [5:0] exp_loads);
        if (exp_loads != 6'b0) sb.push_back({3'b000, exp_loads});
        @(negedge slow_clock);
        deal_req = 1'b1;
        @(negedge slow_clock);
        deal_req = 1'b0;
        @(negedge slow_clock);
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 20; i++) begin
            @(negedge slow_clock);
            if (done) return;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL %s_timeout: got done=0 expected done=1", name);
    endtask

    // One full round: initial two-card scores, optional third cards, final scores.
    task automatic round(input string name,
                         input logic [3:0] p0, input logic [3:0] d0, input logic [3:0] pc3,
                         input bit dp3, input bit dd3,
                         input logic [3:0] pf, input logic [3:0] df,
                         input bit epl, input bit edl);
        pscore = p0;
        dscore = d0;
        pcard3 = pc3;
        step(LP1);
        step(LD1);
        step(LP2);
        step(LD2);
        @(negedge slow_clock);
        if (dp3) begin
            step(LP3);
            @(negedge slow_clock);
        end
        pscore = pf;
        dscore = df;
        if (dd3) step(LD3);
        sb.push_back({1'b1, epl, edl, 6'b0});
        wait_done(name);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_pulse();
        // natural 8 vs 3
        round("natural", 4'd8, 4'd3, 4'd0, 1'b0, 1'b0, 4'd8, 4'd3, 1'b1, 1'b0);
        rst_pulse();
        // player draws 7 -> banker on 6 draws; 9 vs 2
        round("p3_d3", 4'd4, 4'd6, 4'd7, 1'b1, 1'b1, 4'd9, 4'd2, 1'b1, 1'b0);
        rst_pulse();
        // player third card rank 12 (value 0) -> banker on 6 stands; tie 6-6
        round("face_tie", 4'd4, 4'd6, 4'd12, 1'b1, 1'b0, 4'd6, 4'd6, 1'b1, 1'b1);
        rst_pulse();
        // player stands on 7, banker 5 draws; 7 vs 8
        round("pstand_d3", 4'd7, 4'd5, 4'd0, 1'b0, 1'b1, 4'd7, 4'd8, 1'b0, 1'b1);
        rst_pulse();
        // banker 3, player third value 8 -> stand
        round("b3_v8", 4'd2, 4'd3, 4'd8, 1'b1, 1'b0, 4'd5, 4'd3, 1'b1, 1'b0);
        rst_pulse();
        // banker 3, player third value 9 -> draw
        round("b3_v9", 4'd2, 4'd3, 4'd9, 1'b1, 1'b1, 4'd1, 4'd7, 1'b0, 1'b1);
        rst_pulse();
        // both stand: 6 vs 7, player stands, banker above draw limit
        round("both_stand", 4'd6, 4'd7, 4'd0, 1'b0, 1'b0, 4'd6, 4'd7, 1'b0, 1'b1);
        rst_pulse();

        // Held deal_req: one strobe every second cycle, then reset mid-round.
        sb.push_back({3'b000, LP1});
        @(negedge slow_clock);
        deal_req = 1'b1;
        @(negedge slow_clock);
        chk("held_s1", obs, {3'b000, LP1});
        @(negedge slow_clock);
        chk("held_gap", obs, 9'b0);
        @(posedge slow_clock);
        #1 chk("held_s2", obs, {3'b000, LD1});
        resetb = 1'b0;
        #1 chk("reset_mid", obs, 9'b0);
        deal_req = 1'b0;
        @(negedge slow_clock);
        #1 resetb = 1'b1;
        // Restart must begin again at pcard1.
        round("restart", 4'd9, 4'd8, 4'd0, 1'b0, 1'b0, 4'd9, 4'd8, 1'b1, 1'b0);

        // deal_req in DONE: no strobes, lights and done held.
        @(negedge slow_clock);
        deal_req = 1'b1;
        repeat (6) @(negedge slow_clock);
        deal_req = 1'b0;
        chk("done_hold", obs, {3'b110, 6'b0});

        repeat (2) @(negedge slow_clock);
        chk("sb_drain", 9'(sb.size()), 9'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
